// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - issues 8-bit reg-reg instructions against a 4x4-bit register file
// Four-state sequence per instruction: latch/address, operand capture, execute, write-back.
module regfile_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  input  logic [3:0] rf_rda,
  input  logic [3:0] rf_rdb,
  output logic [1:0] rf_wa,
  output logic [3:0] rf_wd,
  output logic       rf_we,
  output logic       done,
  output logic       flag_c,
  output logic       flag_z
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  state_t     state;
  logic [7:0] ir;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       we_q;
  logic [4:0] result;

  // Zero-extended 5-bit arithmetic: bit 4 is carry for ADD and borrow for SUB.
  always_comb begin
    result = 5'b0;
    case (ir[7:6])
      OP_ADD:  result = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  result = {1'b0, opa} - {1'b0, opb};
      OP_AND:  result = {1'b0, opa & opb};
      OP_LDI:  result = {1'b0, ir[3:0]};
      default: result = 5'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= 8'h00;
      opa    <= 4'h0;
      opb    <= 4'h0;
      rf_ra  <= 2'b00;
      rf_rb  <= 2'b00;
      rf_wa  <= 2'b00;
      rf_wd  <= 4'h0;
      we_q   <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_q <= 1'b0;
          if (instr_valid) begin
            ir    <= instr;
            rf_ra <= instr[3:2];
            rf_rb <= instr[1:0];
            state <= READ;
          end
        end
        READ: begin
          opa   <= rf_rda;
          opb   <= rf_rdb;
          state <= EXEC;
        end
        EXEC: begin
          rf_wd  <= result[3:0];
          rf_wa  <= ir[5:4];
          flag_z <= (result[3:0] == 4'h0);
          if (ir[7:6] == OP_ADD || ir[7:6] == OP_SUB)
            flag_c <= result[4];
          we_q   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          we_q  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with rst lets a reset asserted during WB kill the write in that same cycle.
  assign rf_we       = we_q & ~rst;
  assign done        = we_q & ~rst;
  assign instr_ready = (state == IDLE) & ~rst;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed self-checking bench for regfile_sequencer
// Includes a behavioural 4x4-bit register file reset to R0=1, R1=2, R2=4, R3=8.
module tb_regfile_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] rf_ra;
  logic [1:0] rf_rb;
  logic [3:0] rf_rda;
  logic [3:0] rf_rdb;
  logic [1:0] rf_wa;
  logic [3:0] rf_wd;
  logic       rf_we;
  logic       done;
  logic       flag_c;
  logic       flag_z;

  logic       model_load;
  logic [3:0] rf [4];
  int         n_checks;
  int         n_fail;

  regfile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_ra       (rf_ra),
    .rf_rb       (rf_rb),
    .rf_rda      (rf_rda),
    .rf_rdb      (rf_rdb),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .rf_we       (rf_we),
    .done        (done),
    .flag_c      (flag_c),
    .flag_z      (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rda = rf[rf_ra];
  assign rf_rdb = rf[rf_rb];

  always @(posedge clk) begin
    if (model_load) begin
      rf[0] <= 4'b0001;
      rf[1] <= 4'b0010;
      rf[2] <= 4'b0100;
      rf[3] <= 4'b1000;
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_load = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_load = 1'b0;
    @(negedge clk);
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_instr(input string tag, input logic [7:0] ins,
                           input logic [1:0] era, input logic [1:0] erb,
                           input logic [1:0] ewa, input logic [3:0] ewd,
                           input logic ec, input logic ez);
    instr = ins;
    instr_valid = 1'b1;
    check({tag, " ready"}, {7'b0, instr_ready}, 8'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 8'h00;
    check({tag, " read ready"}, {7'b0, instr_ready}, 8'd0);
    check({tag, " rf_ra"}, {6'b0, rf_ra}, {6'b0, era});
    check({tag, " rf_rb"}, {6'b0, rf_rb}, {6'b0, erb});
    @(negedge clk);
    check({tag, " exec we"}, {7'b0, rf_we}, 8'd0);
    @(negedge clk);
    check({tag, " wb we"}, {7'b0, rf_we}, 8'd1);
    check({tag, " wb done"}, {7'b0, done}, 8'd1);
    check({tag, " rf_wa"}, {6'b0, rf_wa}, {6'b0, ewa});
    check({tag, " rf_wd"}, {4'b0, rf_wd}, {4'b0, ewd});
    check({tag, " flag_c"}, {7'b0, flag_c}, {7'b0, ec});
    check({tag, " flag_z"}, {7'b0, flag_z}, {7'b0, ez});
    @(negedge clk);
    check({tag, " idle ready"}, {7'b0, instr_ready}, 8'd1);
    check({tag, " idle we"}, {7'b0, rf_we}, 8'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    model_load = 1'b1;
    instr = 8'h00;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", {7'b0, instr_ready}, 8'd0);
    check("rst we", {7'b0, rf_we}, 8'd0);
    check("rst done", {7'b0, done}, 8'd0);
    check("rst ra", {6'b0, rf_ra}, 8'd0);
    check("rst rb", {6'b0, rf_rb}, 8'd0);
    check("rst wa", {6'b0, rf_wa}, 8'd0);
    check("rst wd", {4'b0, rf_wd}, 8'd0);
    check("rst c", {7'b0, flag_c}, 8'd0);
    check("rst z", {7'b0, flag_z}, 8'd0);
    rst = 1'b0;
    model_load = 1'b0;
    @(negedge clk);

    run_instr("add0b", 8'h0B, 2'd2, 2'd3, 2'd0, 4'b1100, 1'b0, 1'b0);
    check("add0b r0", {4'b0, rf[0]}, 8'h0C);

    do_reset();
    run_instr("add1f", 8'h1F, 2'd3, 2'd3, 2'd1, 4'b0000, 1'b1, 1'b1);

    do_reset();
    run_instr("sub61", 8'h61, 2'd0, 2'd1, 2'd2, 4'b1111, 1'b1, 1'b0);
    run_instr("and99", 8'h99, 2'd2, 2'd1, 2'd1, 4'b0010, 1'b1, 1'b0);
    run_instr("ldifa", 8'hFA, 2'd2, 2'd2, 2'd3, 4'b1010, 1'b1, 1'b0);
    check("ldifa r3", {4'b0, rf[3]}, 8'h0A);

    // Valid held high across two instructions.
    do_reset();
    instr = 8'h0B;
    instr_valid = 1'b1;
    check("b2b ready0", {7'b0, instr_ready}, 8'd1);
    @(negedge clk);
    instr = 8'h20;
    check("b2b gap1", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    check("b2b gap2", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    check("b2b gap3", {7'b0, instr_ready}, 8'd0);
    check("b2b wd1", {4'b0, rf_wd}, 8'h0C);
    @(negedge clk);
    check("b2b ready1", {7'b0, instr_ready}, 8'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b ra2", {6'b0, rf_ra}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b we2", {7'b0, rf_we}, 8'd1);
    check("b2b wa2", {6'b0, rf_wa}, 8'd2);
    check("b2b wd2", {4'b0, rf_wd}, 8'h08);
    check("b2b c2", {7'b0, flag_c}, 8'd1);
    check("b2b z2", {7'b0, flag_z}, 8'd0);
    @(negedge clk);

    // Reset during EXEC discards the instruction and clears flags.
    do_reset();
    run_instr("pre1f", 8'h1F, 2'd3, 2'd3, 2'd1, 4'b0000, 1'b1, 1'b1);
    instr = 8'h0B;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rexec we", {7'b0, rf_we}, 8'd0);
    check("rexec done", {7'b0, done}, 8'd0);
    check("rexec ready", {7'b0, instr_ready}, 8'd0);
    check("rexec ra", {6'b0, rf_ra}, 8'd0);
    check("rexec rb", {6'b0, rf_rb}, 8'd0);
    check("rexec wa", {6'b0, rf_wa}, 8'd0);
    check("rexec wd", {4'b0, rf_wd}, 8'd0);
    check("rexec c", {7'b0, flag_c}, 8'd0);
    check("rexec z", {7'b0, flag_z}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rexec ready after", {7'b0, instr_ready}, 8'd1);
    check("rexec we after", {7'b0, rf_we}, 8'd0);
    check("rexec r0", {4'b0, rf[0]}, 8'h01);

    // Reset during WB suppresses the write in that cycle.
    instr = 8'h0B;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rwb we before", {7'b0, rf_we}, 8'd1);
    rst = 1'b1;
    #1;
    check("rwb we", {7'b0, rf_we}, 8'd0);
    check("rwb done", {7'b0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rwb r0", {4'b0, rf[0]}, 8'h01);
    @(negedge clk);
    check("rwb ready", {7'b0, instr_ready}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
